// File: rtl/fpmul_pkg.sv
// Shared types and sizing helpers for the streaming FP multiplier.
// Rounding mode is chosen by the FPMUL_RNE_EN macro in fpmul_stream.sv.
package fpmul_pkg;

    typedef enum logic [2:0] {
        ST_LOAD_A,
        ST_LOAD_B,
        ST_MUL,
        ST_NORM,
        ST_SEND
    } state_t;

    localparam int FLG_NAN = 3;
    localparam int FLG_INF = 2;
    localparam int FLG_OVF = 1;
    localparam int FLG_UNF = 0;

    function automatic int ni_f(input int fp_w, input int in_w);
        return (fp_w + in_w - 1) / in_w;
    endfunction

    function automatic int no_f(input int fp_w, input int out_w);
        return (fp_w + out_w - 1) / out_w;
    endfunction

    function automatic int bias_f(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fpmul_stream_if.sv
// Operand/result stream bundle between a producer/consumer and fpmul_stream.
// The slave side is the multiplier, the master side drives operands.
interface fpmul_stream_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       flags;
    logic             busy;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, flags, busy
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, flags, busy
    );
endinterface

// File: rtl/fpmul_seq_mult.sv
// Sequential shift-add significand multiplier, one multiplier bit per cycle.
// o_done is high in the cycle whose closing edge writes the final partial sum.
module fpmul_seq_mult #(
    parameter int W = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_start,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic           o_done,
    output logic [2*W-1:0] o_prod
);
    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mplier;
    logic [CW-1:0]  r_cnt;
    logic           r_run;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{W{1'b0}}, i_a};
            r_mplier <= i_b;
            r_cnt    <= '0;
            r_run    <= 1'b1;
        end else if (r_run) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == CW'(W - 1)) r_run <= 1'b0;
        end
    end

    assign o_done = r_run && (r_cnt == CW'(W - 1));
    assign o_prod = r_acc;

endmodule

// File: rtl/fpmul_stream.sv
// Chunk-streamed IEEE-style FP multiplier: load A, load B, shift-add, normalise, send.
// Define FPMUL_RNE_EN for round-to-nearest-even; default truncates toward zero.
module fpmul_stream
    import fpmul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_ni,
    fpmul_stream_if.slave  s_if
);
    localparam int FP_W = 1 + EXP_W + MAN_W;
    localparam int NI   = ni_f(FP_W, IN_W);
    localparam int NO   = no_f(FP_W, OUT_W);
    localparam int SW   = MAN_W + 1;
    localparam int ICW  = $clog2(NI + 1);
    localparam int OCW  = $clog2(NO + 1);
    localparam logic [EXP_W+1:0] BIAS_V = (EXP_W+2)'(bias_f(EXP_W));

    state_t               r_st;
    logic [ICW-1:0]       r_icnt;
    logic [OCW-1:0]       r_ocnt;
    logic [NI*IN_W-1:0]   r_abuf;
    logic [NI*IN_W-1:0]   r_bbuf;
    logic [FP_W-1:0]      r_res;
    logic [3:0]           r_flg;
    logic                 r_start;

    logic [FP_W-1:0]      w_a, w_b, w_res;
    logic [3:0]           w_flg;
    logic                 w_done;
    logic [2*SW-1:0]      w_prod;
    logic [NO*OUT_W-1:0]  w_opad;
    logic                 w_s, w_hi, w_inc;
    logic [EXP_W-1:0]     w_ea, w_eb;
    logic [MAN_W-1:0]     w_fa, w_fb, w_man;
    logic                 w_za, w_zb, w_ia, w_ib, w_na, w_nb;
    logic [MAN_W:0]       w_mr;
    logic [EXP_W+1:0]     w_exp, w_expr;
`ifdef FPMUL_RNE_EN
    logic                 w_g, w_st;
`endif

    assign w_a = r_abuf[FP_W-1:0];
    assign w_b = r_bbuf[FP_W-1:0];

    fpmul_seq_mult #(.W(SW)) u_mult (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .i_start (r_start),
        .i_a     ({1'b1, w_a[MAN_W-1:0]}),
        .i_b     ({1'b1, w_b[MAN_W-1:0]}),
        .o_done  (w_done),
        .o_prod  (w_prod)
    );

    always_comb begin
        w_s  = w_a[FP_W-1] ^ w_b[FP_W-1];
        w_ea = w_a[FP_W-2 -: EXP_W];
        w_eb = w_b[FP_W-2 -: EXP_W];
        w_fa = w_a[MAN_W-1:0];
        w_fb = w_b[MAN_W-1:0];
        w_za = (w_ea == '0);
        w_zb = (w_eb == '0);
        w_ia = (&w_ea) && (w_fa == '0);
        w_ib = (&w_eb) && (w_fb == '0);
        w_na = (&w_ea) && (w_fa != '0);
        w_nb = (&w_eb) && (w_fb != '0);
        w_hi = w_prod[2*SW-1];
        // Product is in [1,4); keep MAN_W bits below the leading one
        if (w_hi) begin
            w_man = w_prod[2*MAN_W -: MAN_W];
        end else begin
            w_man = w_prod[2*MAN_W-1 -: MAN_W];
        end
`ifdef FPMUL_RNE_EN
        if (w_hi) begin
            w_g  = w_prod[MAN_W];
            w_st = |w_prod[MAN_W-1:0];
        end else begin
            w_g  = w_prod[MAN_W-1];
            w_st = |w_prod[MAN_W-2:0];
        end
        w_inc = w_g & (w_st | w_man[0]);
`else
        w_inc = 1'b0;
`endif
        w_mr   = {1'b0, w_man} + {{MAN_W{1'b0}}, w_inc};
        w_exp  = {2'b00, w_ea} + {2'b00, w_eb} - BIAS_V
               + {{(EXP_W+1){1'b0}}, w_hi};
        w_expr = w_exp + {{(EXP_W+1){1'b0}}, w_mr[MAN_W]};
        w_res  = '0;
        w_flg  = '0;
        if (w_na || w_nb || (w_za && w_ib) || (w_ia && w_zb)) begin
            w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            w_flg[FLG_NAN] = 1'b1;
        end else if (w_ia || w_ib) begin
            w_res = {w_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flg[FLG_INF] = 1'b1;
        end else if (w_za || w_zb) begin
            w_res = {w_s, {(FP_W-1){1'b0}}};
        end else if (!w_expr[EXP_W+1] &&
                     (w_expr[EXP_W:0] >= {1'b0, {EXP_W{1'b1}}})) begin
            w_res = {w_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flg[FLG_INF] = 1'b1;
            w_flg[FLG_OVF] = 1'b1;
        end else if (w_expr[EXP_W+1] || (w_expr == '0)) begin
            w_res = {w_s, {(FP_W-1){1'b0}}};
            w_flg[FLG_UNF] = 1'b1;
        end else begin
            w_res = {w_s, w_expr[EXP_W-1:0], w_mr[MAN_W-1:0]};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_st    <= ST_LOAD_A;
            r_icnt  <= '0;
            r_ocnt  <= '0;
            r_abuf  <= '0;
            r_bbuf  <= '0;
            r_res   <= '0;
            r_flg   <= '0;
            r_start <= 1'b0;
        end else begin
            r_start <= 1'b0;
            unique case (r_st)
                ST_LOAD_A: if (s_if.in_valid) begin
                    r_abuf[int'(r_icnt)*IN_W +: IN_W] <= s_if.in_data;
                    if (r_icnt == ICW'(NI - 1)) begin
                        r_icnt <= '0;
                        r_st   <= ST_LOAD_B;
                    end else begin
                        r_icnt <= r_icnt + 1'b1;
                    end
                end
                ST_LOAD_B: if (s_if.in_valid) begin
                    r_bbuf[int'(r_icnt)*IN_W +: IN_W] <= s_if.in_data;
                    if (r_icnt == ICW'(NI - 1)) begin
                        r_icnt  <= '0;
                        r_start <= 1'b1;
                        r_st    <= ST_MUL;
                    end else begin
                        r_icnt <= r_icnt + 1'b1;
                    end
                end
                ST_MUL: if (w_done) r_st <= ST_NORM;
                ST_NORM: begin
                    r_res  <= w_res;
                    r_flg  <= w_flg;
                    r_ocnt <= '0;
                    r_st   <= ST_SEND;
                end
                ST_SEND: if (s_if.out_ready) begin
                    if (r_ocnt == OCW'(NO - 1)) begin
                        r_ocnt <= '0;
                        r_st   <= ST_LOAD_A;
                    end else begin
                        r_ocnt <= r_ocnt + 1'b1;
                    end
                end
                default: r_st <= ST_LOAD_A;
            endcase
        end
    end

    always_comb begin
        w_opad = '0;
        w_opad[FP_W-1:0] = r_res;
    end

    assign s_if.in_ready  = (r_st == ST_LOAD_A) || (r_st == ST_LOAD_B);
    assign s_if.out_valid = (r_st == ST_SEND);
    assign s_if.out_data  = w_opad[int'(r_ocnt)*OUT_W +: OUT_W];
    assign s_if.flags     = r_flg;
    assign s_if.busy      = (r_st != ST_LOAD_A);

endmodule

// File: tb/tb_fpmul_stream.sv
// Directed bench for fpmul_stream with hand-computed IEEE single results.
// Honours FPMUL_RNE_EN for the rounding-sensitive vector.
module tb_fpmul_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    fpmul_stream_if #(.IN_W(16), .OUT_W(8)) s_if ();

    fpmul_stream dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .s_if      (s_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [15:0] d);
        int n;
        s_if.in_data  = d;
        s_if.in_valid = 1'b1;
        n = 0;
        while (!s_if.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("in_ready_timeout", 32'(n), 32'd0);
        tick();
        s_if.in_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] b);
        put(a[15:0]);
        put(a[31:16]);
        put(b[15:0]);
        put(b[31:16]);
    endtask

    task automatic get(output logic [31:0] r, output logic [3:0] f);
        int n;
        r = '0;
        f = '0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!s_if.out_valid && n < 200) begin
                tick();
                n++;
            end
            if (n >= 200) chk("out_valid_timeout", 32'(n), 32'd0);
            r[k*8 +: 8] = s_if.out_data;
            if (k == 0) f = s_if.flags;
            tick();
        end
    endtask

    task automatic op(input string tag, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] er,
                      input logic [3:0] ef);
        logic [31:0] r;
        logic [3:0]  f;
        load(a, b);
        get(r, f);
        chk(tag, r, er);
        chk({tag, "_flags"}, {28'd0, f}, {28'd0, ef});
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  f;
        logic [7:0]  d0;
        logic [3:0]  f0;
        int          lat;

        s_if.in_data   = '0;
        s_if.in_valid  = 1'b0;
        s_if.out_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        chk("rst_out_valid", {31'd0, s_if.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, s_if.in_ready}, 32'd1);
        chk("rst_busy", {31'd0, s_if.busy}, 32'd0);
        chk("rst_out_data", {24'd0, s_if.out_data}, 32'd0);
        chk("rst_flags", {28'd0, s_if.flags}, 32'd0);

        // 1.5 * 2.0 with latency measured from the last B beat
        load(32'h3FC00000, 32'h40000000);
        lat = 0;
        while (!s_if.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'd26);
        get(r, f);
        chk("mul_1p5x2", r, 32'h40400000);
        chk("mul_1p5x2_flags", {28'd0, f}, 32'd0);

        op("zero_x_inf", 32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000);
        op("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0110);
`ifdef FPMUL_RNE_EN
        op("round", 32'h3FC00001, 32'h3FC00001, 32'h40100002, 4'b0000);
`else
        op("round", 32'h3FC00001, 32'h3FC00001, 32'h40100001, 4'b0000);
`endif
        op("nan_in", 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);
        op("inf_x_neg2", 32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0100);
        op("underflow", 32'h80800000, 32'h00800000, 32'h80000000, 4'b0001);
        op("negzero", 32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000);

        // Consumer stall while the first result beat is presented
        s_if.out_ready = 1'b0;
        load(32'h3FC00000, 32'h40000000);
        lat = 0;
        while (!s_if.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk("stall_reach_send", 32'(lat), 32'd26);
        d0 = s_if.out_data;
        f0 = s_if.flags;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {31'd0, s_if.out_valid}, 32'd1);
            chk("stall_data", {24'd0, s_if.out_data}, {24'd0, d0});
            chk("stall_flags", {28'd0, s_if.flags}, {28'd0, f0});
            chk("stall_in_ready", {31'd0, s_if.in_ready}, 32'd0);
        end
        s_if.out_ready = 1'b1;
        get(r, f);
        chk("stall_result", r, 32'h40400000);
        chk("stall_result_flags", {28'd0, f}, 32'd0);

        // Abort mid-multiply with a one-cycle reset pulse
        load(32'h3FC00000, 32'h40000000);
        repeat (5) tick();
        chk("mid_mul_busy", {31'd0, s_if.busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", {31'd0, s_if.busy}, 32'd0);
        chk("abort_out_valid", {31'd0, s_if.out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, s_if.in_ready}, 32'd1);
        op("one_x_one", 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpmul_stream.md
FPMUL_STREAM -- requirements
Module: fpmul_stream

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, meaning stored fraction width; FP_W = 1+EXP_W+MAN_W.
REQ-003 SHALL have parameter IN_W, default 16, meaning operand load chunk width.
REQ-004 SHALL have parameter OUT_W, default 8, meaning result chunk width.
REQ-005 SHALL have port wb_clk_i, input, 1, the only clock; all logic rising-edge.
REQ-006 SHALL have port wb_rst_ni, input, 1; reset is synchronous and active-low.
REQ-007 SHALL have port in_data, input, IN_W, operand chunk.
REQ-008 SHALL have port in_valid, input, 1, chunk valid.
REQ-009 SHALL have port in_ready, output, 1, chunk accepted when in_valid&in_ready.
REQ-010 SHALL have port out_data, output, OUT_W, result chunk.
REQ-011 SHALL have port out_valid, output, 1, result chunk valid.
REQ-012 SHALL have port out_ready, input, 1, result chunk consumed when out_valid&out_ready.
REQ-013 SHALL have port flags, output, 4, {nan, inf, overflow, underflow} for the current result; stable while out_valid.
REQ-014 SHALL have port busy, output, 1, high in any state other than LOAD_A.

Function
REQ-015 SHALL load operand A then B, each in NI=ceil(FP_W/IN_W) beats, least significant chunk first; excess bits of the final chunk ignored.
REQ-016 SHALL use states LOAD_A, LOAD_B, MUL, NORM, SEND; LOAD_A->LOAD_B after NI A-beats; LOAD_B->MUL after NI B-beats; MUL->NORM after MAN_W+1 cycles; NORM->SEND after 1 cycle; SEND->LOAD_A after last output beat accepted.
REQ-017 SHALL assert in_ready only in LOAD_A and LOAD_B.
REQ-018 SHALL compute the (MAN_W+1)x(MAN_W+1) significand product by sequential shift-add, one multiplier bit per MUL cycle.
REQ-019 SHALL in NORM compute sign XOR, exponent ea+eb-bias (+1 if product >= 2), normalise, round, and classify.
REQ-020 SHALL treat zero exponent as zero (subnormals flushed), all-ones exponent with zero fraction as inf, non-zero fraction as NaN.
REQ-021 SHALL output canonical quiet NaN (sign 0, exponent all-ones, fraction MSB only) for any NaN input or zero*inf, setting nan.
REQ-022 SHALL output signed inf for inf*nonzero with inf flag; on exponent overflow (including rounding carry) output signed inf with overflow and inf flags.
REQ-023 SHALL output signed zero when biased exponent <= 0, setting underflow unless an input was zero.
REQ-024 SHALL emit the result in NO=ceil(FP_W/OUT_W) beats, least significant first, zero-padded; out_valid held with stable out_data until accepted.
REQ-025 SHALL have total latency from last B-beat to first out_valid of MAN_W+3 cycles, independent of out_ready.

Reset
REQ-026 SHALL on wb_rst_ni low at a clock edge enter LOAD_A, clear beat counters, operands, product and flags; out_valid=0, in_ready=1 in the cycle after release, busy=0, out_data=0.
REQ-027 SHALL abort any in-flight operation when reset is asserted mid-operation; no partial result emitted afterwards.

Configuration
REQ-028 SHALL round toward zero (truncate) when FPMUL_RNE_EN is undefined.
REQ-029 SHALL round to nearest, ties to even, using guard and sticky bits when FPMUL_RNE_EN is defined; latency unchanged.

Structure
REQ-030 SHALL place state enum, flag bit indices, and NI/NO/bias derivation functions in shared package fpmul_pkg.
REQ-031 SHALL implement the sequential shift-add multiplier as sub-module fpmul_seq_mult (start, done, operands, product).

Verification
REQ-032 SHALL check A=0x3FC00000, B=0x40000000 (beats 0x0000,0x3FC0,0x0000,0x4000) -> bytes 0x00,0x00,0x40,0x40 (0x40400000), flags 0, first out_valid 26 cycles after last B-beat.
REQ-033 SHALL check A=0x00000000, B=0x7F800000 -> 0x7FC00000, flags nan=1.
REQ-034 SHALL check A=B=0x7F000000 -> 0x7F800000, overflow=1, inf=1.
REQ-035 SHALL check A=B=0x3FC00001 -> 0x40100001 without FPMUL_RNE_EN, 0x40100002 with it.
REQ-036 SHALL check out_ready low for 5 cycles during SEND -> out_data/out_valid/flags stable, no beat lost, in_ready=0 throughout.
REQ-037 SHALL check wb_rst_ni low for 1 cycle during MUL -> next cycle LOAD_A, busy=0, out_valid=0; fresh 1.0*1.0 (0x3F800000) then yields 0x3F800000.
